// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty-cycle decoder.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DIVIDE  = 2'd2
  } pwm_dec_state_t;

  localparam int DIV_STEPS     = 8;
  localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/pwm_serial_divider.sv
// Restoring bit-serial divider: quotient = floor(dividend * 2^8 / divisor),
// one bit per cycle, MSB first. Assumes dividend < divisor and divisor > 0.
module pwm_serial_divider
  import pwm_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [7:0]       quotient,
  output logic             done
);

  localparam int STEP_W = $clog2(DIV_STEPS);

  logic [CNT_W-1:0]     rem_q;
  logic [CNT_W-1:0]     div_q;
  logic [DIV_STEPS-2:0] quo_q;
  logic [STEP_W-1:0]    step_q;
  logic                 busy_q;

  logic [CNT_W:0]   shifted;
  logic             q_bit;
  logic [CNT_W-1:0] next_rem;

  // The remainder stays below the divisor, so the shift needs only one extra bit
  // and the restored or subtracted remainder always fits back into CNT_W bits.
  always_comb begin
    shifted  = {rem_q, 1'b0};
    q_bit    = (shifted >= {1'b0, div_q});
    next_rem = q_bit ? CNT_W'(shifted - {1'b0, div_q}) : shifted[CNT_W-1:0];
    quotient = {quo_q, q_bit};
    done     = busy_q && (step_q == STEP_W'(DIV_STEPS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      div_q  <= '0;
      quo_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= dividend;
      div_q  <= divisor;
      quo_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= next_rem;
      quo_q  <= quotient[DIV_STEPS-2:0];
      step_q <= step_q + STEP_W'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures period and high time of an asynchronous PWM input and reports
// duty = floor(high*256/period), with stuck-input and overrun flags.
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       pwm_in,
  output logic [7:0] duty,
  output logic       duty_valid,
  output logic       stuck,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   synced;
  logic                   rise;

  pwm_dec_state_t   state;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] high_cnt;

  logic       div_start;
  logic [7:0] div_quotient;
  logic       div_done;

  assign synced    = sync_q[SYNC_STAGES-1];
  assign rise      = synced & ~prev_q;
  assign div_start = ena && (state == MEASURE) && rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage sample the value its
      // predecessor held before the edge, which is what forms the chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_q <= synced;
    end
  end

  pwm_serial_divider #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (high_cnt),
    .divisor  (per_cnt),
    .quotient (div_quotient),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      per_cnt    <= '0;
      high_cnt   <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      stuck      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      overrun    <= 1'b0;
      if (!ena) begin
        state    <= IDLE;
        per_cnt  <= '0;
        high_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              per_cnt  <= CNT_W'(1);
              high_cnt <= CNT_W'(1);
              state    <= MEASURE;
            end else begin
              per_cnt  <= '0;
              high_cnt <= '0;
            end
          end

          MEASURE: begin
            if (rise) begin
              per_cnt  <= CNT_W'(1);
              high_cnt <= CNT_W'(1);
              state    <= DIVIDE;
            end else if (per_cnt == CNT_MAX) begin
              duty       <= synced ? 8'hFF : 8'h00;
              duty_valid <= 1'b1;
              stuck      <= 1'b1;
              per_cnt    <= '0;
              high_cnt   <= '0;
              state      <= IDLE;
            end else begin
              per_cnt  <= per_cnt + CNT_W'(1);
              high_cnt <= high_cnt + CNT_W'(synced);
            end
          end

          DIVIDE: begin
            // Counters keep running so the following window is measured; an
            // edge here closes a window too short to divide, so it is dropped.
            if (rise) begin
              per_cnt  <= CNT_W'(1);
              high_cnt <= CNT_W'(1);
              overrun  <= 1'b1;
            end else begin
              per_cnt  <= per_cnt + CNT_W'(1);
              high_cnt <= high_cnt + CNT_W'(synced);
            end
            if (div_done) begin
              duty       <= div_quotient;
              duty_valid <= 1'b1;
              stuck      <= 1'b0;
              state      <= MEASURE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed self-checking bench for pwm_duty_decoder with hand-computed duties.
module tb_pwm_duty_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] duty;
  logic       duty_valid;
  logic       stuck;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int ovr_cnt = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  int exp_duty = 0;
  int v;
  int o;
  int t0;

  always #5 clk = ~clk;

  pwm_duty_decoder #(
    .CNT_W       (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .duty_valid (duty_valid),
    .stuck      (stuck),
    .overrun    (overrun)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Every duty update is compared against the duty the current stimulus implies.
  always @(negedge clk) begin
    if (rst_n) begin
      if (duty_valid) begin
        valid_cnt++;
        check("duty_at_valid", {24'd0, duty}, exp_duty);
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
      end
      if (overrun) ovr_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pwm_periods(input int n, input int hi, input int lo);
    repeat (n) begin
      pwm_in = 1'b1;
      tick(hi);
      pwm_in = 1'b0;
      tick(lo);
    end
  endtask

  task automatic idle_gap();
    ena = 1'b0;
    tick(4);
    ena = 1'b1;
    tick(4);
  endtask

  initial begin
    tick(3);
    check("rst_duty", {24'd0, duty}, 0);
    check("rst_valid", {31'd0, duty_valid}, 0);
    check("rst_stuck", {31'd0, stuck}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    rst_n = 1'b1;
    ena   = 1'b1;
    tick(5);

    // 25/100 -> 64, one result per period from the second edge on
    exp_duty = 64;
    v = valid_cnt;
    pwm_periods(5, 25, 75);
    check("a_valid_count", valid_cnt - v, 4);
    check("a_interval", last_valid_cyc - prev_valid_cyc, 100);
    check("a_duty", {24'd0, duty}, 64);
    check("a_stuck", {31'd0, stuck}, 0);
    idle_gap();

    // 3/10 -> 76, then 1/256 -> 1; first 1/256 edge closes a 3/10 window
    exp_duty = 76;
    v = valid_cnt;
    o = ovr_cnt;
    pwm_periods(6, 3, 7);
    pwm_periods(1, 1, 255);
    check("b_valid_count", valid_cnt - v, 6);
    check("b_duty", {24'd0, duty}, 76);
    exp_duty = 1;
    pwm_periods(2, 1, 255);
    check("c_valid_count", valid_cnt - v, 8);
    check("c_duty", {24'd0, duty}, 1);
    check("bc_overrun", ovr_cnt - o, 0);
    idle_gap();

    // period 6: every other window lands during DIVIDE and is dropped
    exp_duty = 128;
    v = valid_cnt;
    o = ovr_cnt;
    pwm_periods(10, 3, 3);
    tick(20);
    check("d_valid_count", valid_cnt - v, 5);
    check("d_overrun_count", ovr_cnt - o, 4);
    check("d_duty", {24'd0, duty}, 128);
    idle_gap();

    // one edge then held high -> timeout at 2^16-1 reports 255 and stuck
    exp_duty = 255;
    v = valid_cnt;
    pwm_in = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 70000 && valid_cnt == v; i++) tick(1);
    check("e_timeout_valid", valid_cnt - v, 1);
    check("e_timeout_cycle", last_valid_cyc - t0, 65538);
    check("e_stuck_set", {31'd0, stuck}, 1);
    check("e_duty_255", {24'd0, duty}, 255);
    exp_duty = 128;
    v = valid_cnt;
    pwm_in = 1'b0;
    tick(10);
    pwm_periods(1, 10, 10);
    check("e_stuck_hold", {31'd0, stuck}, 1);
    pwm_periods(2, 10, 10);
    check("e_recover_valid", valid_cnt - v, 2);
    check("e_stuck_clear", {31'd0, stuck}, 0);
    check("e_recover_duty", {24'd0, duty}, 128);

    // reset in DIVIDE cycle 4: rise seen 3 cycles after drive, +4 more
    exp_duty = 10;
    v = valid_cnt;
    pwm_in = 1'b1;
    tick(2);
    pwm_in = 1'b0;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("f_rst_duty", {24'd0, duty}, 0);
    check("f_rst_valid", {31'd0, duty_valid}, 0);
    check("f_rst_stuck", {31'd0, stuck}, 0);
    check("f_rst_overrun", {31'd0, overrun}, 0);
    tick(1);
    rst_n = 1'b1;
    tick(20);
    check("f_no_partial", valid_cnt - v, 0);
    pwm_periods(1, 2, 48);
    check("f_no_early_result", valid_cnt - v, 0);
    pwm_periods(2, 2, 48);
    check("f_valid_count", valid_cnt - v, 2);
    check("f_duty", {24'd0, duty}, 10);

    // ena dropped mid-MEASURE: nothing reported, duty holds, fresh start after
    v = valid_cnt;
    o = ovr_cnt;
    pwm_in = 1'b1;
    tick(10);
    pwm_in = 1'b0;
    tick(10);
    check("g_pre_valid", valid_cnt - v, 1);
    v = valid_cnt;
    ena = 1'b0;
    tick(20);
    pwm_periods(1, 10, 30);
    check("g_off_valid", valid_cnt - v, 0);
    check("g_off_overrun", ovr_cnt - o, 0);
    check("g_off_duty", {24'd0, duty}, 10);
    exp_duty = 64;
    ena = 1'b1;
    tick(2);
    pwm_periods(3, 10, 30);
    check("g_valid_count", valid_cnt - v, 2);
    check("g_duty", {24'd0, duty}, 64);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
